mix_columns_seq: RTL and testbench
==================================

// Module: mix_columns_seq
// PURPOSE
//  AES MixColumns round stage, consumes the 128-bit output of the ShiftRows stage.
//  Processes COLS_PER_CYCLE columns per clock over 4/COLS_PER_CYCLE cycles and holds the result until accepted.
//  Uses a valid/ready handshake on both sides, so the round controller can stall it.
//  Supports a bypass for the AES final round, which omits MixColumns.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns mixed per clock; legal values 1, 2 or 4 (elaboration error otherwise)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_state/in_bypass valid
//  in_ready   out  1    block can accept a new state
//  in_state   in   128  ShiftRows output, [0:127]
//  in_bypass  in   1    1 = final round, pass state through unmixed
//  out_valid  out  1    out_state valid
//  out_ready  in   1    downstream accepts out_state
//  out_state  out  128  mixed state, [0:127]
//  in_inv     in   1    1 = InvMixColumns (port present only when MIX_INV_EN is defined)
// BEHAVIOUR
//  - Byte layout: byte k = bits [8k:8k+7], bit 8k is the MSB. Column c = bytes 4c..4c+3 (a0..a3).
//  - Reset (async, rst_n=0): FSM=IDLE, col counter=0, out_valid=0, out_state=128'h0.
//    - in_ready=1 once in IDLE. A reset mid-operation discards the state in flight.
//  - FSM states IDLE -> BUSY -> DONE -> IDLE:
//    - IDLE: in_ready=1. When in_valid, latch in_state into the work register and capture in_bypass (and in_inv).
//      - Go to DONE if bypass, else go to BUSY with col=0.
//    - BUSY: in_ready=0. Each cycle, columns col..col+COLS_PER_CYCLE-1 of the work register are replaced in place.
//      - col advances by COLS_PER_CYCLE. After column 3 is written, go to DONE.
//    - DONE: out_valid=1 and out_state=work register, both stable while out_ready=0.
//      - When out_ready, go to IDLE; out_valid drops next cycle.
//  - No overlap: a new input is not accepted in the cycle the output is consumed. in_ready is a pure function of the FSM state.
//  - Latency from the accept edge to out_valid: 4/COLS_PER_CYCLE + 1 cycles when mixing; 1 cycle when bypassing.
//    - With COLS_PER_CYCLE=1 the block is occupied 5 cycles plus the drain cycle.
//  - Arithmetic in GF(2^8), all 8-bit, XOR only:
//    - xtime(b) = (b<<1)[7:0] ^ (b MSB ? 8'h1b : 8'h00).
//    - Forward: r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
//  - out_state is 0 until the first result is produced. It is not cleared on return to IDLE.
//  - in_state changes while in_ready=0 are ignored.
// CONFIGURATION
//  MIX_INV_EN defined:
//    - Adds the in_inv port, captured at accept.
//    - in_inv=1 applies InvMixColumns: r0=e*a0^b*a1^d*a2^9*a3, with rows rotated for r1..r3 (coefficients 0e,0b,0d,09).
//    - Bypass takes priority over in_inv.
//  MIX_INV_EN undefined:
//    - No in_inv port; forward only.
//    - No inverse multiplier logic is synthesised.
// TESTING
//  1) rst_n low mid-BUSY -> out_valid=0, out_state=0, in_ready=1 asynchronously; the next transfer completes correctly.
//  2) in_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_state=046681e5_e0cb199a_48f8d37a_2806264c.
//     - out_valid exactly 5 cycles after accept for COLS_PER_CYCLE=1; 2 cycles for COLS_PER_CYCLE=4.
//  3) Columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6 (xtime reduction, identity columns).
//  4) in_bypass=1 with the vector from 2) -> out_state equals in_state, out_valid 1 cycle after accept.
//  5) out_ready held low 10 cycles in DONE -> out_valid and out_state stable, in_ready=0.
//     - Back-to-back in_valid: the second state is accepted only in IDLE.
//  6) MIX_INV_EN build, in_inv=1, column 8e4da1bc -> db135345.
//     - Random forward-then-inverse round trip returns the original state.

Source files
------------

// File: rtl/mix_columns_seq.sv
// AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Optional InvMixColumns (in_inv port) when MIX_INV_EN is defined.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_bypass,
`ifdef MIX_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  // state  | meaning
  // S_IDLE | ready for a new state
  // S_BUSY | mixing columns in place in the work register
  // S_DONE | result presented, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t       r_state, w_next;
  logic [1:0]   r_col;
  logic [0:127] r_work, r_out;
  logic [0:127] w_work_nx;
  logic         w_last;
  logic [31:0]  w_mix  [COLS_PER_CYCLE];
  logic [6:0]   w_base [COLS_PER_CYCLE];
`ifdef MIX_INV_EN
  logic         r_inv;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_INV_EN
  // 9/b/d/e multiples built from the x2/x4/x8 chain of each byte.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    {a[0], a[1], a[2], a[3]} = c;
    for (int k = 0; k < 4; k++) begin
      x2 = xt(a[k]);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
      logic [1:0]  w_idx;
      logic [31:0] w_cin;
      assign w_idx     = r_col + 2'(j);
      assign w_base[j] = {w_idx, 5'b0};
      assign w_cin     = r_work[w_base[j] +: 32];
`ifdef MIX_INV_EN
      assign w_mix[j]  = r_inv ? mix_inv(w_cin) : mix_fwd(w_cin);
`else
      assign w_mix[j]  = mix_fwd(w_cin);
`endif
    end
  endgenerate

  always_comb begin
    w_work_nx = r_work;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_work_nx[w_base[j] +: 32] = w_mix[j];
    end
  end

  assign w_last = (r_col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = in_bypass ? S_DONE : S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // r_out is a separate holding register so out_state keeps the last result while a new state is worked on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= 2'd0;
      r_work <= '0;
      r_out  <= '0;
`ifdef MIX_INV_EN
      r_inv  <= 1'b0;
`endif
    end else if (r_state == S_IDLE && in_valid) begin
      r_work <= in_state;
      r_col  <= 2'd0;
      if (in_bypass) r_out <= in_state;
`ifdef MIX_INV_EN
      r_inv  <= in_inv;
`endif
    end else if (r_state == S_BUSY) begin
      r_work <= w_work_nx;
      r_col  <= r_col + STEP;
      if (w_last) r_out <= w_work_nx;
    end
  end

  assign out_state = r_out;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed + randomized bench for mix_columns_seq against a GF(2^8) matrix reference model.
module tb_mix_columns_seq;
  localparam int CPC     = 1;
  localparam int LAT_MIX = 4 / CPC + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_state = '0;
  logic         in_bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_state;
`ifdef MIX_INV_EN
  logic         in_inv = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
`ifdef MIX_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  logic [7:0] FWD_M [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  logic [7:0] INV_M [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix: row r, byte k uses coefficient M[(k - r) mod 4].
  function automatic logic [0:127] model(input logic [0:127] s, input bit byp, input bit inv);
    logic [0:127] r;
    logic [7:0]   a [4];
    logic [7:0]   acc, coef;
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[32*c + 8*k +: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          coef = inv ? INV_M[(k - rr + 4) % 4] : FWD_M[(k - rr + 4) % 4];
          acc ^= gmul(coef, a[k]);
        end
        r[32*c + 8*rr +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [0:127] s, input bit byp, input bit inv);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", 128'(in_ready), 128'(1'b1));
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
`ifdef MIX_INV_EN
    in_inv    = inv;
`else
    if (inv) $display("note: inverse request ignored in forward-only build");
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_drain", 128'(out_valid), 128'(1'b0));
    chk("in_ready_after_drain", 128'(in_ready), 128'(1'b1));
  endtask

  task automatic xfer(input string tag, input logic [0:127] s, input bit byp, input bit inv,
                      input logic [0:127] exp);
    int lat;
    send(s, byp, inv);
    wait_out(lat);
    chk({tag, "_latency"}, 128'(lat), byp ? 128'(1) : 128'(LAT_MIX));
    chk({tag, "_data"}, out_state, exp);
    chk({tag, "_model"}, out_state, model(s, byp, inv));
    drain();
  endtask

  logic [0:127] v_a, v_b, v_y, v_exp;
  int           lat;
  bit           byp;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xfer("fips_vec", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
         128'h046681e5_e0cb199a_48f8d37a_2806264c);
    xfer("xtime_ident", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    xfer("bypass", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 1'b0,
         128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    // After drain out_state keeps the last result
    chk("out_state_held_idle", out_state, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);

    // Stall in DONE with a second state already offered
    v_a = {$urandom, $urandom, $urandom, $urandom};
    v_b = {$urandom, $urandom, $urandom, $urandom};
    send(v_a, 1'b0, 1'b0);
    chk("busy_in_ready", 128'(in_ready), 128'(1'b0));
    wait_out(lat);
    chk("stall_latency", 128'(lat), 128'(LAT_MIX));
    in_valid = 1'b1;
    in_state = v_b;
    in_bypass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", 128'(out_valid), 128'(1'b1));
      chk("stall_out_state", out_state, model(v_a, 1'b0, 1'b0));
      chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
      @(negedge clk);
    end
    drain();
    send(v_b, 1'b0, 1'b0);
    wait_out(lat);
    chk("b2b_latency", 128'(lat), 128'(LAT_MIX));
    chk("b2b_data", out_state, model(v_b, 1'b0, 1'b0));
    drain();

    // Randomized forward / bypass traffic
    for (int i = 0; i < 8; i++) begin
      v_a = {$urandom, $urandom, $urandom, $urandom};
      byp = ($urandom_range(0, 3) == 0);
      send(v_a, byp, 1'b0);
      wait_out(lat);
      chk("rand_latency", 128'(lat), byp ? 128'(1) : 128'(LAT_MIX));
      chk("rand_data", out_state, model(v_a, byp, 1'b0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drain();
    end

    // Reset in the middle of BUSY
    send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0);
    @(negedge clk);
    chk("midbusy_in_ready", 128'(in_ready), 128'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_out_state", out_state, 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer("post_rst", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

`ifdef MIX_INV_EN
    xfer("inv_vec", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 1'b1,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    xfer("inv_bypass_prio", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b1,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    for (int i = 0; i < 4; i++) begin
      v_a = {$urandom, $urandom, $urandom, $urandom};
      send(v_a, 1'b0, 1'b0);
      wait_out(lat);
      v_y = out_state;
      chk("rt_fwd", v_y, model(v_a, 1'b0, 1'b0));
      drain();
      send(v_y, 1'b0, 1'b1);
      wait_out(lat);
      chk("rt_latency", 128'(lat), 128'(LAT_MIX));
      chk("rt_inv", out_state, v_a);
      drain();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
